// File: rtl/gas_pkg.sv
// rtl/gas_pkg.sv - shared alarm levels, frame width and threshold defaults
package gas_pkg;

   // Thermometer-coded alarm levels as seen by the house controller
   typedef enum logic [2:0] {
      LVL_CLEAR = 3'b000,
      LVL_LOW   = 3'b001,
      LVL_MED   = 3'b011,
      LVL_HIGH  = 3'b111
   } level_t;

   localparam int          FRAME_W_DEF = 12;
   localparam logic [11:0] TH_LOW_DEF  = 12'h100;
   localparam logic [11:0] TH_MED_DEF  = 12'h400;
   localparam logic [11:0] TH_HIGH_DEF = 12'h800;
   localparam int          CONFIRM_DEF = 2;

endpackage

// File: rtl/gas_detector_sensor_if.sv
// rtl/gas_detector_sensor_if.sv - serial sensor input and alarm level output bundle
interface gas_detector_sensor_if;

   logic       din;
   logic [2:0] dout;

   modport master (output din, input dout);
   modport slave  (input din, output dout);

endinterface

// File: rtl/gas_level_classifier.sv
// rtl/gas_level_classifier.sv - combinational frame-to-alarm-level mapping
module gas_level_classifier
   import gas_pkg::*;
#(
   parameter int                 FRAME_W = FRAME_W_DEF,
   parameter logic [FRAME_W-1:0] TH_LOW  = TH_LOW_DEF,
   parameter logic [FRAME_W-1:0] TH_MED  = TH_MED_DEF,
   parameter logic [FRAME_W-1:0] TH_HIGH = TH_HIGH_DEF
) (
   input  logic [FRAME_W-1:0] frame,
   output level_t             level
);

   // Highest threshold wins so overlapping ranges resolve to the most severe level
   always_comb begin
      level = LVL_CLEAR;
      if (frame >= TH_HIGH) begin
         level = LVL_HIGH;
      end else if (frame >= TH_MED) begin
         level = LVL_MED;
      end else if (frame >= TH_LOW) begin
         level = LVL_LOW;
      end
   end

endmodule

// File: rtl/gas_detector_sensor.sv
// rtl/gas_detector_sensor.sv - deserialises sensor frames and drives a debounced alarm level
module gas_detector_sensor
   import gas_pkg::*;
#(
   parameter int                 FRAME_W = FRAME_W_DEF,
   parameter logic [FRAME_W-1:0] TH_LOW  = TH_LOW_DEF,
   parameter logic [FRAME_W-1:0] TH_MED  = TH_MED_DEF,
   parameter logic [FRAME_W-1:0] TH_HIGH = TH_HIGH_DEF,
   parameter int                 CONFIRM = CONFIRM_DEF
) (
   input  logic                  clk,
   input  logic                  arst,
   gas_detector_sensor_if.slave  bus
);

   localparam int                CNT_W    = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);
   localparam logic [3:0]        CONF_Q   = 4'(CONFIRM);

   logic [FRAME_W-1:0] seq;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] frame;
   logic               frame_done;
   level_t             cand;
   level_t             last_cand;
   level_t             dout_q;
   logic [2:0]         agree;
   logic [3:0]         agree_next;

   // The 12th bit is folded in combinationally so the level updates on that same edge
   assign frame      = {seq[FRAME_W-2:0], bus.din};
   assign frame_done = (bit_cnt == LAST_BIT);
   assign agree_next = {1'b0, agree} + 4'd1;
   assign bus.dout   = dout_q;

   gas_level_classifier #(
      .FRAME_W (FRAME_W),
      .TH_LOW  (TH_LOW),
      .TH_MED  (TH_MED),
      .TH_HIGH (TH_HIGH)
   ) u_classifier (
      .frame (frame),
      .level (cand)
   );

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         seq       <= '0;
         bit_cnt   <= '0;
         dout_q    <= LVL_CLEAR;
         last_cand <= LVL_CLEAR;
         agree     <= '0;
      end else begin
         seq     <= frame;
         bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
         if (frame_done) begin
            if (cand == LVL_HIGH) begin
               // Danger level skips debounce entirely
               dout_q    <= LVL_HIGH;
               agree     <= '0;
               last_cand <= LVL_HIGH;
            end else if (cand == last_cand) begin
               if (agree_next <= CONF_Q) begin
                  agree <= agree_next[2:0];
               end
               if (agree_next >= CONF_Q) begin
                  dout_q <= cand;
               end
            end else begin
               agree     <= 3'd1;
               last_cand <= cand;
               if (CONFIRM == 1) begin
                  dout_q <= cand;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gas_detector_sensor.sv
// tb/tb_gas_detector_sensor.sv - directed vector bench for gas_detector_sensor
module tb_gas_detector_sensor;

   logic clk;
   logic arst;
   int   n_checks;
   int   n_fail;

   gas_detector_sensor_if bus ();

   gas_detector_sensor dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [11:0] frame;
      logic [2:0]  exp;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input logic [2:0] act, input logic [2:0] exp, input string nm);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: dout=%b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Drives one frame MSB first; dout must hold until the 12th edge, then show exp
   task automatic send_frame(input logic [11:0] v, input logic [2:0] prev,
                             input logic [2:0] exp, input string nm);
      for (int i = 11; i >= 0; i--) begin
         @(negedge clk);
         bus.din = v[i];
         @(posedge clk);
         #1;
         if (i > 0) check(bus.dout, prev, {nm, " hold"});
         else       check(bus.dout, exp, nm);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      arst     = 1'b0;
      bus.din  = 1'b0;

      vecs[0]  = '{12'h000, 3'b000};
      vecs[1]  = '{12'h200, 3'b000};
      vecs[2]  = '{12'h200, 3'b001};
      vecs[3]  = '{12'h0FF, 3'b001};
      vecs[4]  = '{12'h0FF, 3'b000};
      vecs[5]  = '{12'h100, 3'b000};
      vecs[6]  = '{12'h100, 3'b001};
      vecs[7]  = '{12'h3FF, 3'b001};
      vecs[8]  = '{12'h3FF, 3'b001};
      vecs[9]  = '{12'h400, 3'b001};
      vecs[10] = '{12'h400, 3'b011};
      vecs[11] = '{12'h0FF, 3'b011};
      vecs[12] = '{12'h0FF, 3'b000};
      vecs[13] = '{12'h500, 3'b000};
      vecs[14] = '{12'h200, 3'b000};
      vecs[15] = '{12'h500, 3'b000};
      vecs[16] = '{12'h500, 3'b011};
      vecs[17] = '{12'h900, 3'b111};
      vecs[18] = '{12'h900, 3'b111};
      vecs[19] = '{12'h7FF, 3'b111};
      vecs[20] = '{12'h7FF, 3'b011};
      vecs[21] = '{12'h800, 3'b111};
      vecs[22] = '{12'hFFF, 3'b111};

      // Reset held with din toggling
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.din = ~bus.din;
         @(posedge clk);
         #1;
         check(bus.dout, 3'b000, "reset hold");
      end
      @(posedge clk);
      #1;
      arst = 1'b1;

      begin
         logic [2:0] prev;
         prev = 3'b000;
         for (int k = 0; k < NVEC; k++) begin
            send_frame(vecs[k].frame, prev, vecs[k].exp, $sformatf("vec%0d", k));
            prev = vecs[k].exp;
         end
      end

      // Partial frame then asynchronous reset mid-cycle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.din = 1'b1;
         @(posedge clk);
         #1;
         check(bus.dout, 3'b111, "pre-reset hold");
      end
      #2;
      arst = 1'b0;
      #1;
      check(bus.dout, 3'b000, "async reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      check(bus.dout, 3'b000, "reset held");
      arst = 1'b1;

      send_frame(12'h200, 3'b000, 3'b000, "post-reset f1");
      send_frame(12'h200, 3'b000, 3'b001, "post-reset f2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
